// File: rtl/q3fsm_pkg.sv
// q3fsm_pkg: shared state encoding, window length and fill default for q3fsm_tx
package q3fsm_pkg;
  localparam int WIN_LEN = 3;
  localparam logic [WIN_LEN-1:0] FILL_DEFAULT = 3'b000;
  typedef enum logic [2:0] {IDLE, SYNC, BIT0, BIT1, BIT2} state_t;
  // a window makes the detector raise z when exactly two of its bits are set
  function automatic logic two_ones(input logic [WIN_LEN-1:0] p);
    return $countones(p) == 2;
  endfunction
endpackage

// File: rtl/q3fsm_tx_fifo.sv
// q3fsm_tx_fifo: synchronous pattern FIFO, power-of-two depth, no read bypass
module q3fsm_tx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rdata = mem[rptr];
  // pointers and occupancy; reset flushes the buffer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/q3fsm_tx.sv
// q3fsm_tx: window transmitter for the 3-bit detector; Q3FSM_TX_UNDERRUN_CNT_EN adds underrun_cnt
module q3fsm_tx
  import q3fsm_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter logic [WIN_LEN-1:0] FILL_PATTERN = FILL_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pat_valid,
  output logic               pat_ready,
  input  logic [WIN_LEN-1:0] pat_data,
  output logic               s,
  output logic               w,
  output logic               busy,
  output logic               exp_z,
  output logic               underrun
`ifdef Q3FSM_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]         underrun_cnt
`endif
);
  state_t state, nxt;
  logic [WIN_LEN-1:0] win, head;
  logic pend, full, empty, load, done, pop;
  assign pat_ready = ~full;
  q3fsm_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WIN_LEN)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(pat_valid),
    .pop(pop),
    .wdata(pat_data),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  // next state, window load decision and detector-facing outputs
  always_comb begin
    nxt = state;
    done = state == BIT2 && (pend || stop);
    load = state == SYNC || (state == BIT2 && !done);
    pop = load & ~empty;
    underrun = load & empty;
    s = state == SYNC;
    busy = state != IDLE;
    w = state == BIT0 ? win[0] : state == BIT1 ? win[1] : state == BIT2 ? win[2] : 1'b0;
    unique case (state)
      IDLE:    nxt = start ? SYNC : IDLE;
      SYNC:    nxt = BIT0;
      BIT0:    nxt = BIT1;
      BIT1:    nxt = BIT2;
      BIT2:    nxt = done ? IDLE : BIT0;
      default: nxt = IDLE;
    endcase
  end
  // state, current window, stop-pending flag and predicted detector z
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      win <= '0;
      pend <= 1'b0;
      exp_z <= 1'b0;
    end else begin
      state <= nxt;
      if (load) win <= empty ? FILL_PATTERN : head;
      pend <= done ? 1'b0 : (stop && (state != IDLE || start)) ? 1'b1 : pend;
      exp_z <= state == BIT2 && two_ones(win);
    end
`ifdef Q3FSM_TX_UNDERRUN_CNT_EN
  // saturating count of fill substitutions
  always_ff @(posedge clk or posedge reset)
    if (reset) underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_q3fsm_tx.sv
// tb_q3fsm_tx: directed and random checks of q3fsm_tx against a queue-based model; honours Q3FSM_TX_UNDERRUN_CNT_EN
module tb_q3fsm_tx;
  import q3fsm_pkg::*;
  localparam int DEPTH = 2;
  localparam logic [2:0] FILL = 3'b000;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, pat_valid = 1'b0;
  logic [2:0] pat_data = 3'b000;
  logic pat_ready, s, w, busy, exp_z, underrun;
`ifdef Q3FSM_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif
  int n_assert = 0, n_fail = 0;
  // model: pattern queue, phase (0 idle, 1 sync, 2..4 = bit 0..2), current window
  logic [2:0] mq [$];
  int ph, mcnt;
  logic [2:0] mwin;
  bit mpend, mexpz;

  always #5 clk = ~clk;

  q3fsm_tx #(.FIFO_DEPTH(DEPTH), .FILL_PATTERN(FILL)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .pat_valid(pat_valid),
    .pat_ready(pat_ready),
    .pat_data(pat_data),
    .s(s),
    .w(w),
    .busy(busy),
    .exp_z(exp_z),
    .underrun(underrun)
`ifdef Q3FSM_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    ph = 0;
    mpend = 0;
    mexpz = 0;
    mcnt = 0;
    mwin = 3'b000;
  endtask

  // a new window is taken when entering bit 0: from sync, or after bit 2 unless the session ends
  function automatic bit m_load();
    return ph == 1 || (ph == 4 && !(mpend || stop));
  endfunction

  task automatic check_all();
    chk("s", s, ph == 1);
    chk("w", w, ph >= 2 ? mwin[ph-2] : 1'b0);
    chk("busy", busy, ph != 0);
    chk("pat_ready", pat_ready, mq.size() < DEPTH);
    chk("exp_z", exp_z, mexpz);
    chk("underrun", underrun, m_load() && mq.size() == 0);
`ifdef Q3FSM_TX_UNDERRUN_CNT_EN
    chk8("underrun_cnt", underrun_cnt, 8'(mcnt));
`endif
  endtask

  task automatic m_step();
    bit push, endf, ld;
    if (reset) begin
      m_reset();
      return;
    end
    push = pat_valid && mq.size() < DEPTH;
    endf = ph == 4 && (mpend || stop);
    ld = m_load();
    mexpz = ph == 4 && $countones(mwin) == 2;
    if (ld) begin
      if (mq.size() > 0) mwin = mq.pop_front();
      else begin
        mwin = FILL;
        if (mcnt < 255) mcnt++;
      end
    end
    if (push) mq.push_back(pat_data);
    if (endf) mpend = 0;
    else if (stop && (ph != 0 || start)) mpend = 1;
    ph = ph == 0 ? (start ? 1 : 0) : ph == 4 ? (endf ? 0 : 2) : ph + 1;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_ph(input int p);
    for (int k = 0; k < 20 && ph != p; k++) cyc();
  endtask

  task automatic push1(input logic [2:0] d);
    pat_valid = 1'b1;
    pat_data = d;
    cyc();
    pat_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    run(2);
    reset = 1'b0;
    // single 011 window
    push1(3'b011);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("sync_s", s, 1'b1);
    cyc();
    chk("win011_w0", w, 1'b1);
    cyc();
    chk("win011_w1", w, 1'b1);
    cyc();
    chk("win011_w2", w, 1'b0);
    cyc();
    chk("win011_expz", exp_z, 1'b1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    run(2);
    chk("stop_idle_busy", busy, 1'b0);
    // two windows then fill underruns
    push1(3'b111);
    push1(3'b101);
    chk("full_ready", pat_ready, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(14);
    wait_ph(2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    run(3);
    chk("stop2_busy", busy, 1'b0);
    // third offer while full is refused, drain in order
    pat_valid = 1'b1;
    pat_data = 3'b110;
    cyc();
    pat_data = 3'b001;
    cyc();
    pat_data = 3'b100;
    cyc();
    pat_valid = 1'b0;
    chk("three_ready", pat_ready, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("first_pop_ready", pat_ready, 1'b1);
    run(6);
    wait_ph(2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    run(3);
    // start and stop together send one window
    push1(3'b010);
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    run(4);
    chk("one_window_busy", busy, 1'b0);
    run(2);
    // reset in the middle of a window
    push1(3'b110);
    push1(3'b011);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_ph(3);
    #2 reset = 1'b1;
    #1;
    chk("rst_s", s, 1'b0);
    chk("rst_w", w, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_expz", exp_z, 1'b0);
    chk("rst_ready", pat_ready, 1'b1);
    m_reset();
    run(2);
    reset = 1'b0;
    run(6);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      pat_valid = 1'($urandom_range(0, 1));
      pat_data = 3'($urandom);
      start = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 11) == 0;
      cyc();
    end
    pat_valid = 1'b0;
    start = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    run(8);
`ifdef Q3FSM_TX_UNDERRUN_CNT_EN
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(800);
    chk8("cnt_sat", underrun_cnt, 8'd255);
    run(6);
    chk8("cnt_hold", underrun_cnt, 8'd255);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/q3fsm_tx.md
Q3FSM_TX -- requirements
Module: q3fsm_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: pattern buffer entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter FILL_PATTERN, default 3'b000: window sent when the buffer is empty at a window boundary.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse that begins a session; honoured only in IDLE.
REQ-006 stop  in  1  single-cycle pulse that ends the session at the next window boundary.
REQ-007 pat_valid  in  1  pattern offer.
REQ-008 pat_ready  out  1  buffer not full.
REQ-009 pat_data  in  3  window pattern; bit 0 is sent first.
REQ-010 s  out  1  start strobe to the window detector.
REQ-011 w  out  1  serial window bit to the detector.
REQ-012 busy  out  1  high in every state other than IDLE.
REQ-013 exp_z  out  1  predicted detector z.
REQ-014 underrun  out  1  single-cycle pulse when FILL_PATTERN is substituted.
REQ-015 underrun_cnt  out  8  saturating underrun count; present only with the macro defined (REQ-034).

Function
REQ-016 FSM states SHALL be IDLE, SYNC, BIT0, BIT1, BIT2, with s and w driven combinationally from the state register and the shift register.
REQ-017 Transitions: IDLE->SYNC on start; SYNC->BIT0; BIT0->BIT1; BIT1->BIT2; BIT2->IDLE if stop is pending, else BIT2->BIT0.
REQ-018 s SHALL be 1 only in SYNC; w SHALL be 0 in IDLE and SYNC.
REQ-019 In BIT0, BIT1 and BIT2, w SHALL equal bit 0, 1 and 2 respectively of the current window.
REQ-020 The current window SHALL be loaded on each transition into BIT0: the buffer head is popped if the buffer is non-empty; otherwise FILL_PATTERN is loaded and underrun pulses in the same cycle as the load edge.
REQ-021 A push SHALL occur when pat_valid and pat_ready are both high, in any state, including IDLE pre-load.
REQ-022 The buffer SHALL NOT bypass: a push and a load in the same cycle on an empty buffer SHALL still substitute FILL_PATTERN.
REQ-023 A push and a pop in the same cycle SHALL leave the buffer occupancy unchanged.
REQ-024 pat_ready SHALL be 0 exactly when the buffer holds FIFO_DEPTH entries.
REQ-025 exp_z SHALL be registered.
REQ-026 exp_z SHALL be 1 for exactly the one cycle after BIT2 whose window has popcount 2; this cycle may be IDLE. The timing matches detector z one cycle after the third bit.
REQ-027 stop SHALL set a pending flag that clears on BIT2->IDLE; stop in IDLE SHALL be ignored.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 If start and stop arrive in the same IDLE cycle, the session SHALL start and end after its first window.
REQ-030 Buffer contents SHALL survive a stop; the next session SHALL consume them in order.

Reset
REQ-031 Asserting reset at any time, including mid-window, SHALL force IDLE, flush the buffer, and clear the stop-pending flag.
REQ-032 Under reset: s=0, w=0, busy=0, exp_z=0, underrun=0, underrun_cnt=0, pat_ready=1.
REQ-033 The first start SHALL be accepted in the first cycle after reset deasserts.

Configuration
REQ-034 With Q3FSM_TX_UNDERRUN_CNT_EN defined, underrun_cnt SHALL exist, increment on each underrun pulse, and saturate at 255.
REQ-035 Without the macro, the port and the counter SHALL be absent; the underrun pulse SHALL remain.

Structure
REQ-036 Package q3fsm_pkg SHALL hold the state enum, WIN_LEN=3, and the default fill constant.
REQ-037 The pattern buffer SHALL be a sub-module, q3fsm_tx_fifo (synchronous FIFO, parameterised depth and width).

Verification
REQ-038 Pre-load 3'b011, then pulse start -> s=1 for 1 cycle; w=1,1,0 over the next 3 cycles; exp_z=1 in the following cycle.
REQ-039 Push 3'b111 then 3'b101, no stop -> w=1,1,1,1,0,1; exp_z=0 after window 1 and 1 after window 2; then FILL windows with 2 underrun pulses within 6 further cycles.
REQ-040 Push 2 patterns while in IDLE -> pat_ready=0; third pat_valid is not accepted; start drains in order and pat_ready returns to 1 on the first pop.
REQ-041 Pulse stop during BIT0 -> the window completes through BIT2, then IDLE with busy=0; pulse start with stop in IDLE -> exactly one window is sent.
REQ-042 Assert reset during BIT1 -> s=w=busy=exp_z=0 immediately; buffer is empty (pat_ready=1); no exp_z afterwards.
REQ-043 With the macro defined, run 260 empty windows -> underrun_cnt=255 and holds.
